// File: rtl/vend_pkg.sv
// Shared definitions for the vending credit controller.
//   - FSM state encoding (2-bit)
//   - coin value constants and coin-select codes
//   - coin_value(): maps a coin-select code to its value in coin units
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } vend_state_e;

    localparam logic [3:0] COIN_1 = 4'd1;
    localparam logic [3:0] COIN_2 = 4'd2;
    localparam logic [3:0] COIN_5 = 4'd5;

    localparam logic [1:0] SEL_COIN_1 = 2'b00;
    localparam logic [1:0] SEL_COIN_2 = 2'b01;
    localparam logic [1:0] SEL_COIN_5 = 2'b10;
    localparam logic [1:0] SEL_INVALID = 2'b11;

    // An invalid code maps to 0 so the adder output is harmless; the
    // controller rejects that coin anyway.
    function automatic logic [3:0] coin_value(input logic [1:0] sel);
        logic [3:0] val;
        case (sel)
            SEL_COIN_1: val = COIN_1;
            SEL_COIN_2: val = COIN_2;
            SEL_COIN_5: val = COIN_5;
            default:    val = 4'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/parallel_adder.sv
// 4-bit parallel adder shared by the credit controller.
// Ports:
//   a, b  in  4  operands
//   cin   in  1  carry in
//   sum   out 4  a + b + cin (low 4 bits)
//   cout  out 1  carry out
module parallel_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'd0, cin};

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending machine credit controller.
// Accumulates coins into a registered credit through the shared
// parallel_adder, dispenses once credit reaches PRICE, and returns
// change (or a refund) through a valid/ack handshake.
// Ports:
//   clk           in  1  system clock, rising edge
//   rst_n         in  1  synchronous active-low reset
//   coin_valid    in  1  coin strobe
//   coin_sel      in  2  coin type (00=1, 01=2, 10=5, 11=invalid)
//   cancel        in  1  refund request
//   change_ack    in  1  change taken downstream
//   credit        out 4  running credit
//   dispense      out 1  vend pulse
//   coin_reject   out 1  coin-return pulse
//   change_valid  out 1  change_amt valid, held until acked
//   change_amt    out 4  amount to return
//   busy          out 1  in DISPENSE or CHANGE
// Build option: define VEND_CANCEL_EN to enable the cancel/refund path;
// otherwise cancel is ignored.
//
// state    | meaning
// IDLE     | no credit held
// ACCUM    | credit held, collecting coins
// DISPENSE | one-cycle vend, change computed by subtraction
// CHANGE   | change_amt presented until acked
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter logic [3:0] PRICE = 4'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_sel,
    input  logic       cancel,
    input  logic       change_ack,
    output logic [3:0] credit,
    output logic       dispense,
    output logic       coin_reject,
    output logic       change_valid,
    output logic [3:0] change_amt,
    output logic       busy
);

    vend_state_e state_q, state_d;
    logic [3:0]  credit_q, credit_d;
    logic [3:0]  change_amt_q, change_amt_d;
    logic        dispense_q, dispense_d;
    logic        coin_reject_q, coin_reject_d;
    logic        change_valid_q, change_valid_d;
    logic        busy_q, busy_d;

    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  sum;
    logic        cout;
    logic        accepting;
    logic        vend_pending;
    logic        cancel_req;

    assign accepting    = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign vend_pending = (state_q == ST_ACCUM) && (credit_q >= PRICE);

`ifdef VEND_CANCEL_EN
    assign cancel_req = cancel && accepting && !vend_pending;
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_req    = 1'b0;
`endif

    // Subtract mode in DISPENSE: credit + ~PRICE + 1 = credit - PRICE.
    always_comb begin
        add_b   = coin_value(coin_sel);
        add_cin = 1'b0;
        if (state_q == ST_DISPENSE) begin
            add_b   = ~PRICE;
            add_cin = 1'b1;
        end
    end

    parallel_adder u_adder (
        .a    (credit_q),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            credit_q       <= 4'd0;
            change_amt_q   <= 4'd0;
            dispense_q     <= 1'b0;
            coin_reject_q  <= 1'b0;
            change_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_amt_q   <= change_amt_d;
            dispense_q     <= dispense_d;
            coin_reject_q  <= coin_reject_d;
            change_valid_q <= change_valid_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        change_amt_d  = change_amt_q;
        coin_reject_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (cancel_req) begin
                    coin_reject_d = coin_valid;
                    credit_d      = 4'd0;
                    if (credit_q != 4'd0) begin
                        change_amt_d = credit_q;
                        state_d      = ST_CHANGE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (vend_pending) begin
                    // Credit must stay frozen until the vend subtracts PRICE.
                    coin_reject_d = coin_valid;
                    state_d       = ST_DISPENSE;
                end else if (coin_valid) begin
                    if ((coin_sel == SEL_INVALID) || cout) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = sum;
                        state_d  = ST_ACCUM;
                    end
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_valid;
                change_amt_d  = sum;
                credit_d      = 4'd0;
                state_d       = (sum != 4'd0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                if (change_ack) begin
                    change_amt_d = 4'd0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered copies of the next-state decode so
    // they line up with the state they describe.
    always_comb begin
        dispense_d     = (state_d == ST_DISPENSE);
        change_valid_d = (state_d == ST_CHANGE);
        busy_d         = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
    end

    assign credit       = credit_q;
    assign dispense     = dispense_q;
    assign coin_reject  = coin_reject_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign busy         = busy_q;

endmodule

// File: doc/vend_credit_ctrl.md
# vend_credit_ctrl

Sequential credit controller for the vending machine datapath, sitting directly around the 4-bit `parallel_adder`. It turns coin events into adder operands and registers the adder's `sum`/`cout` as the running credit. It also drives the adder in subtract mode (`b = ~PRICE`, `cin = 1`) to compute change. A small FSM sequences accumulation, dispense and change return.

## Interface
Parameters:
- `PRICE`, 4'd7, item price in coin units (1..15)

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `coin_valid`  in  1  one-cycle coin-inserted strobe
- `coin_sel`  in  2  coin type: 00=1, 01=2, 10=5, 11=invalid
- `cancel`  in  1  refund request (level, sampled per cycle)
- `change_ack`  in  1  downstream has taken `change_amt`
- `credit`  out  4  registered running credit
- `dispense`  out  1  one-cycle vend pulse
- `coin_reject`  out  1  one-cycle coin-return pulse
- `change_valid`  out  1  `change_amt` is valid; held until acked
- `change_amt`  out  4  amount to return
- `busy`  out  1  high in DISPENSE or CHANGE

## Operation
- States: IDLE, ACCUM, DISPENSE, CHANGE.
- Adder operand mux:
  - IDLE/ACCUM: `a = credit`, `b = coin value`, `cin = 0`.
  - DISPENSE: `a = credit`, `b = ~PRICE`, `cin = 1`.
- IDLE/ACCUM with `coin_valid`:
  - Valid coin and `cout = 0`: `credit <= sum`, next state ACCUM.
  - `coin_sel = 11` or `cout = 1` (overflow past 15): `coin_reject` pulse, credit unchanged.
- ACCUM: when registered `credit >= PRICE`, next state is DISPENSE.
- DISPENSE: lasts one cycle.
  - `dispense = 1`.
  - `change_amt <= sum` (`credit − PRICE`, 4-bit).
  - `credit <= 0`.
  - Next state is CHANGE if the difference is nonzero, else IDLE.
- CHANGE: `change_valid = 1` and `change_amt` is held stable until a cycle with `change_ack = 1`. Then go to IDLE and clear `change_amt` to 0.
- Cancel (ACCUM, no DISPENSE pending): `change_amt <= credit`, `credit <= 0`, go to CHANGE. Cancel with `credit = 0` goes to IDLE and produces no change.
- `coin_valid` in DISPENSE or CHANGE: coin rejected (`coin_reject` pulse).
- `coin_valid` and `cancel` in the same cycle: cancel wins, coin rejected.
- `cancel` in DISPENSE or CHANGE: ignored.

## Timing
- Reset values:
  - `credit = 0`, `change_amt = 0`.
  - `dispense = 0`, `coin_reject = 0`, `change_valid = 0`, `busy = 0`.
  - State is IDLE.
- Reset mid-operation discards credit and any pending change.
- Coin to `credit` update: 1 cycle.
- Credit reaching `PRICE` to `dispense`: 1 cycle later (cycle n+1 after the edge at which `credit` updates).
- `change_valid` asserts the cycle after `dispense`.
- `change_ack` while `change_valid` is low is ignored.
- `change_valid` deasserts the cycle after an ack is sampled.
- `coin_reject` fires in the cycle following the offending `coin_valid`. All outputs are registered.

## Configuration
- `VEND_CANCEL_EN` defined: the `cancel` input and the refund path are present as specified above.
- `VEND_CANCEL_EN` undefined:
  - `cancel` is ignored; the port is kept for interface stability.
  - CHANGE is entered only from DISPENSE.
  - Coins still accumulate until `PRICE` is reached.

## Structure
- Shared package `vend_pkg`:
  - State encoding constants (2-bit).
  - Coin value constants `COIN_1 = 4'd1`, `COIN_2 = 4'd2`, `COIN_5 = 4'd5`.
  - Coin-select codes.
- One sub-module: the existing `parallel_adder`, instantiated once. It is shared between the add and subtract uses through the operand mux.
- No other arithmetic except the `credit >= PRICE` compare.

## Test plan
- Exact price: reset, then coins 5, 2 (`PRICE = 7`) → credit 5, 7; `dispense` pulse 1 cycle later; no `change_valid`; credit returns to 0.
- Overpay: coins 5, 5 → credit 10; `dispense`; `change_valid` with `change_amt = 3`, held 4 cycles until `change_ack`; then IDLE.
- Overflow/invalid: with `PRICE = 15`, coins 5, 5, 2, 2 → credit 14. Then coin 5 → `coin_reject`, credit stays 14. Then `coin_sel = 11` → `coin_reject`.
- Cancel: coins 2, 2 → credit 4; `cancel` → `change_amt = 4`, `change_valid`, credit 0. Simultaneous `coin_valid` (1) + `cancel` at credit 4 → reject plus refund of 4. Without `VEND_CANCEL_EN`, credit stays 4 and no change is produced.
- Busy rejection: a coin during DISPENSE or CHANGE → `coin_reject`, credit and `change_amt` unchanged.
- Reset mid-CHANGE: `rst_n` low for 1 cycle while `change_valid = 1` → all outputs 0, state IDLE, next coin 1 → credit 1.
